// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered sprite ROM between NUM_REQ pixel requesters.
// Fixed two-cycle request-to-response pipeline; out-of-range coordinates return TRANSPARENT.
module sprite_rom_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         SPR_W       = 126,
    parameter int         SPR_H       = 60,
    parameter logic [3:0] TRANSPARENT = 4'h0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_x,
    input  logic [NUM_REQ*6-1:0] req_y,
    output logic [NUM_REQ-1:0]   grant,
    output logic [12:0]          rom_addr,
    input  logic [3:0]           rom_data,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [3:0]           rsp_data,
    output logic                 rsp_oob
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          found;
    logic [6:0]    sel_x;
    logic [5:0]    sel_y;
    logic          sel_oob;
    logic [12:0]   sel_addr;

    logic          s1_valid;
    logic [IW-1:0] s1_idx;
    logic          s1_oob;

    // Search starts just past the last winner, so the previous winner ends up last in line.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (Reset) begin
            found = 1'b0;
        end
        grant = '0;
        if (found) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IW'(k)) begin
                sel_x = req_x[k*7 +: 7];
                sel_y = req_y[k*6 +: 6];
            end
        end
        sel_oob  = (int'(sel_x) >= SPR_W) || (int'(sel_y) >= SPR_H);
        sel_addr = 13'(sel_y) * 13'(SPR_W) + 13'(sel_x);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant <= IW'(NUM_REQ - 1);
            rom_addr   <= '0;
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s1_oob     <= 1'b0;
            rsp_valid  <= '0;
            rsp_oob    <= 1'b0;
        end else begin
            if (found) begin
                last_grant <= win_idx;
                if (!sel_oob) begin
                    rom_addr <= sel_addr;
                end
            end
            s1_valid  <= found;
            s1_idx    <= win_idx;
            s1_oob    <= sel_oob;
            rsp_valid <= s1_valid ? (NUM_REQ'(1) << s1_idx) : '0;
            rsp_oob   <= s1_valid & s1_oob;
        end
    end

    // The ROM's own output register lands in the response cycle; the select terms are registers,
    // so this mux stays glitch-free and reads zero while no response is valid.
    assign rsp_data = (|rsp_valid) ? (rsp_oob ? TRANSPARENT : rom_data) : 4'h0;

endmodule
